// File: rtl/mod_accum_pkg.sv
// Shared types and parameter defaults for the modular frame accumulator.
// The state encoding is fixed at 2 bits so it can be probed and compared directly.
package mod_accum_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_EMIT = 2'd2,
        ST_HALT = 2'd3
    } state_e;

    localparam int DEF_W      = 8;
    localparam int DEF_MOD    = 251;
    localparam int DEF_LEN    = 4;
    localparam int DEF_FRAMES = 0;

    // Width of the frame counter when the block never halts (it saturates).
    localparam int FRAME_CNT_W = 16;

endpackage

// File: rtl/mod_accum_add.sv
// Combinational modular adder: both operands are already below MOD, so one
// conditional subtract at W+1 bits is enough to bring the sum back into range.
module mod_add
    import mod_accum_pkg::*;
#(
    parameter int W   = DEF_W,
    parameter int MOD = DEF_MOD
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum
);

    localparam logic [W:0] MOD_X = MOD[W:0];

    logic [W:0] raw;

    assign raw = {1'b0, a} + {1'b0, b};
    assign sum = (raw >= MOD_X) ? W'(raw - MOD_X) : raw[W-1:0];

endmodule

// File: rtl/mod_accum.sv
// Frame accumulator: sums LEN samples modulo MOD, offers the result with a
// valid/ready handshake, and optionally halts after FRAMES results.
module mod_accum
    import mod_accum_pkg::*;
#(
    parameter int W      = DEF_W,
    parameter int MOD    = DEF_MOD,
    parameter int LEN    = DEF_LEN,
    parameter int FRAMES = DEF_FRAMES
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    input  logic         out_ready,
    output logic         cont
);

    localparam int             CW       = $clog2(LEN + 1);
    localparam logic [CW-1:0]  LEN_C    = CW'(LEN);
    localparam int             FW       = (FRAMES == 0) ? FRAME_CNT_W : $clog2(FRAMES + 1);
    localparam logic [FW-1:0]  FRAMES_C = FW'(FRAMES);
    localparam logic [W-1:0]   MOD_C    = MOD[W-1:0];

    state_e        state_q;
    logic [W-1:0]  acc_q;
    logic [W-1:0]  out_data_q;
    logic [CW-1:0] count_q;
    logic [FW-1:0] frames_q;

    logic [W-1:0]  sample_r;
    logic [W-1:0]  acc_d;
    logic [CW-1:0] count_d;
    logic [FW-1:0] frames_d;

    // Constant divisor, so this elaborates to fixed reduction logic.
    assign sample_r = in_data % MOD_C;

    mod_add #(
        .W   (W),
        .MOD (MOD)
    ) u_add (
        .a   (acc_q),
        .b   (sample_r),
        .sum (acc_d)
    );

    assign count_d  = count_q + CW'(1);
    assign frames_d = (frames_q == '1) ? frames_q : frames_q + FW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            acc_q      <= '0;
            out_data_q <= '0;
            count_q    <= '0;
            frames_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        acc_q   <= sample_r;
                        count_q <= CW'(1);
                        if (LEN == 1) begin
                            out_data_q <= sample_r;
                            state_q    <= ST_EMIT;
                        end else begin
                            state_q <= ST_ACC;
                        end
                    end
                end
                ST_ACC: begin
                    if (in_valid) begin
                        acc_q   <= acc_d;
                        count_q <= count_d;
                        if (count_d == LEN_C) begin
                            out_data_q <= acc_d;
                            state_q    <= ST_EMIT;
                        end
                    end
                end
                ST_EMIT: begin
                    if (out_ready) begin
                        frames_q <= frames_d;
                        if (FRAMES != 0 && frames_d == FRAMES_C) begin
                            state_q <= ST_HALT;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= ST_HALT;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == ST_IDLE) || (state_q == ST_ACC);
    assign out_valid = (state_q == ST_EMIT);
    assign out_data  = out_data_q;
    assign cont      = (state_q != ST_HALT);

endmodule

// File: tb/tb_mod_accum.sv
// Bench for mod_accum (W=8, MOD=251, LEN=4, FRAMES=2): table-driven frames
// plus hand-written backpressure, halt and mid-frame reset sequences.
module tb_mod_accum;

    localparam int W      = 8;
    localparam int MOD    = 251;
    localparam int LEN    = 4;
    localparam int FRAMES = 2;

    typedef struct {
        logic [3:0][W-1:0] s;
        logic [W-1:0]      res;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         out_ready = 1'b1;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         cont;

    int           n_cmp = 0;
    int           n_bad = 0;
    logic [W-1:0] exp_q[$];
    vec_t         vecs[8];

    mod_accum #(
        .W      (W),
        .MOD    (MOD),
        .LEN    (LEN),
        .FRAMES (FRAMES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .cont      (cont)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Scoreboard: every result handshake pops the oldest expected value.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_result: got %0d, required no result", out_data);
            end else begin
                check("result", 32'(out_data), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_data", 32'(out_data), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_cont", 32'(cont), 1);
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_out_valid", 32'(out_valid), 0);
        check("post_rst_out_data", 32'(out_data), 0);
        check("post_rst_in_ready", 32'(in_ready), 1);
        check("post_rst_cont", 32'(cont), 1);
        $display("reset applied and released");
    endtask

    // s[3] is the first sample offered.
    task automatic feed_frame(input logic [3:0][W-1:0] s, input logic [W-1:0] res, input bit last);
        exp_q.push_back(res);
        out_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            in_valid = 1'b1;
            in_data  = s[3-j];
            check("in_ready_accept", 32'(in_ready), 1);
            tick();
        end
        in_valid = 1'b0;
        check("latency_out_valid", 32'(out_valid), 1);
        check("emit_in_ready", 32'(in_ready), 0);
        tick();
        check("after_emit_out_valid", 32'(out_valid), 0);
        check("after_emit_in_ready", 32'(in_ready), last ? 0 : 1);
        check("after_emit_cont", 32'(cont), last ? 0 : 1);
        $display("frame %0d %0d %0d %0d -> expect %0d", s[3], s[2], s[1], s[0], res);
    endtask

    task automatic halt_check();
        in_valid = 1'b1;
        in_data  = 8'd3;
        for (int k = 0; k < 20; k++) begin
            tick();
            check("halt_cont", 32'(cont), 0);
            check("halt_in_ready", 32'(in_ready), 0);
            check("halt_out_valid", 32'(out_valid), 0);
        end
        in_valid = 1'b0;
        $display("halt held for 20 cycles");
    endtask

    initial begin
        vecs[0].s = {8'd10, 8'd20, 8'd30, 8'd40};     vecs[0].res = 8'd100;
        vecs[1].s = {8'd250, 8'd250, 8'd1, 8'd3};     vecs[1].res = 8'd2;
        vecs[2].s = {8'd255, 8'd0, 8'd0, 8'd0};       vecs[2].res = 8'd4;
        vecs[3].s = {8'd1, 8'd1, 8'd1, 8'd1};         vecs[3].res = 8'd4;
        vecs[4].s = {8'd251, 8'd251, 8'd251, 8'd251}; vecs[4].res = 8'd0;
        vecs[5].s = {8'd255, 8'd255, 8'd255, 8'd255}; vecs[5].res = 8'd16;
        vecs[6].s = {8'd200, 8'd100, 8'd50, 8'd25};   vecs[6].res = 8'd124;
        vecs[7].s = {8'd128, 8'd128, 8'd128, 8'd128}; vecs[7].res = 8'd10;

        do_reset();

        // Pairs of frames: the second of each pair halts the block.
        for (int i = 0; i < 8; i++) begin
            feed_frame(vecs[i].s, vecs[i].res, (i % 2) == 1);
            if ((i % 2) == 1) begin
                halt_check();
                do_reset();
            end
        end

        // Backpressure: result must hold while out_ready is low.
        exp_q.push_back(8'd4);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data = 8'd255; tick();
        in_data = 8'd0;   tick();
        in_data = 8'd0;   tick();
        in_data = 8'd0;   tick();
        in_data = 8'd99;
        for (int k = 0; k < 5; k++) begin
            in_valid = (k % 2) == 0;
            check("bp_out_valid", 32'(out_valid), 1);
            check("bp_out_data", 32'(out_data), 4);
            check("bp_in_ready", 32'(in_ready), 0);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("bp_release_valid", 32'(out_valid), 1);
        tick();
        check("bp_after_valid", 32'(out_valid), 0);
        check("bp_after_in_ready", 32'(in_ready), 1);
        $display("backpressure frame 255 0 0 0 held 5 cycles");
        feed_frame({8'd5, 8'd5, 8'd5, 8'd5}, 8'd20, 1'b1);
        halt_check();
        do_reset();

        // Reset in the middle of a frame discards the partial sum.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data = 8'd7; tick();
        in_data = 8'd8; tick();
        in_valid = 1'b0;
        rst      = 1'b1;
        #1;
        check("midrst_out_valid", 32'(out_valid), 0);
        check("midrst_in_ready", 32'(in_ready), 1);
        tick();
        rst = 1'b0;
        tick();
        $display("mid-frame reset after samples 7 8");
        feed_frame({8'd1, 8'd1, 8'd1, 8'd1}, 8'd4, 1'b0);

        tick();
        check("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
